// File: rtl/ext_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_uart_tx_pkg
// Description : Shared constants for the EXT-channel UART transmitter.
//               TX state encodings are global `define values so that both
//               the FSM and any observer use one encoding.
//               Optional feature macro: EXT_UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef EXT_UART_TX_STATES_DEFINED
`define EXT_UART_TX_STATES_DEFINED
`define TX_IDLE   3'd0
`define TX_START  3'd1
`define TX_DATA   3'd2
`define TX_PARITY 3'd3
`define TX_STOP   3'd4
`endif

package ext_uart_tx_pkg;

    // Width of one transported byte.
    localparam int   C_BYTE_W    = 8;
    // Width of the TX state register.
    localparam int   C_STATE_W   = 3;
    // Line level of an idle UART (also the stop-bit level).
    localparam logic C_UART_IDLE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ext_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ext_uart_tx_fifo
// Description : Small synchronous byte FIFO feeding the UART shifter.
//               Read data is presented combinationally from the head entry.
//   clk   in   system clock
//   reset in   synchronous active-high reset (clears pointers and count)
//   push  in   write din on this edge (ignored when full)
//   din   in   byte to write
//   pop   in   advance the head on this edge (ignored when empty)
//   dout  out  head entry
//   count out  number of stored bytes, 0..FIFO_DEPTH
//   full  out  count == FIFO_DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module ext_uart_tx_fifo
    import ext_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [C_BYTE_W-1:0] din,
    input  logic                pop,
    output logic [C_BYTE_W-1:0] dout,
    output logic [FIFO_AW:0]    count,
    output logic                full
);

    localparam int               C_CNT_W    = FIFO_AW + 1;
    localparam logic [FIFO_AW:0] C_FULL_CNT = FIFO_DEPTH[FIFO_AW:0];

    logic [C_BYTE_W-1:0] r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  r_wr_ptr;
    logic [FIFO_AW-1:0]  r_rd_ptr;
    logic [FIFO_AW:0]    r_count;
    logic                w_do_push;
    logic                w_do_pop;

    // Protect the pointers even if a caller violates the handshake.
    assign w_do_push = push && (r_count != C_FULL_CNT);
    assign w_do_pop  = pop  && (r_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            r_count <= r_count + C_CNT_W'(w_do_push) - C_CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset; only entries behind the pointers are read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == C_FULL_CNT);

endmodule
`default_nettype wire

// File: rtl/ext_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : ext_uart_tx
// Description : Device-side endpoint of the CPU EXT output channel. Bytes
//               written on cq/cwre are queued and sent as UART frames on txd
//               (8N1, or 8E1 when EXT_UART_TX_PARITY_EN is defined).
//   clk   in   system clock
//   reset in   synchronous active-high reset, aborts any frame in flight
//   cq    in   byte from the EXT channel
//   cwre  in   write strobe, accepted when cbsy is low
//   cbsy  out  registered FIFO-full indication (stalls the writer)
//   txd   out  registered serial line, idle high
//   idle  out  registered, FIFO empty and shifter idle
// Revision    : 1.0 - initial release
// ============================================================================
module ext_uart_tx
    import ext_uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [C_BYTE_W-1:0] cq,
    input  logic                cwre,
    output logic                cbsy,
    output logic                txd,
    output logic                idle
);

    localparam int                  C_BAUD_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [C_BAUD_W-1:0] C_BAUD_RELOAD = C_BAUD_W'(CLK_DIV - 1);
    localparam int                  C_CNT_W       = FIFO_AW + 1;
    localparam logic [FIFO_AW:0]    C_FULL_CNT    = FIFO_DEPTH[FIFO_AW:0];

    logic [C_STATE_W-1:0] r_state;
    logic [C_STATE_W-1:0] w_state_next;
    logic [C_BAUD_W-1:0]  r_baud;
    logic [2:0]           r_bit_idx;
    logic [C_BYTE_W-1:0]  r_shift;
    logic                 r_txd;
    logic                 r_cbsy;
    logic                 r_idle;
`ifdef EXT_UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic [C_BYTE_W-1:0]  w_fifo_dout;
    logic [FIFO_AW:0]     w_fifo_count;
    logic                 w_fifo_full;
    logic [FIFO_AW:0]     w_count_next;

    // The registered cbsy always equals the FIFO's full flag, so the FIFO
    // flag gates the push directly.
    assign w_push       = cwre && !w_fifo_full;
    assign w_bit_end    = (r_baud == '0);
    assign w_count_next = w_fifo_count + C_CNT_W'(w_push) - C_CNT_W'(w_pop);

    ext_uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (cq),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full)
    );

    // Next state and pop decision; pops happen only on the IDLE edge or on
    // the last STOP cycle so consecutive frames run without a gap.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            `TX_IDLE: begin
                if (w_fifo_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = `TX_START;
                end
            end
            `TX_START: begin
                if (w_bit_end) w_state_next = `TX_DATA;
            end
            `TX_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef EXT_UART_TX_PARITY_EN
                    w_state_next = `TX_PARITY;
`else
                    w_state_next = `TX_STOP;
`endif
                end
            end
`ifdef EXT_UART_TX_PARITY_EN
            `TX_PARITY: begin
                if (w_bit_end) w_state_next = `TX_STOP;
            end
`endif
            `TX_STOP: begin
                if (w_bit_end) begin
                    if (w_fifo_count != '0) begin
                        w_pop        = 1'b1;
                        w_state_next = `TX_START;
                    end else begin
                        w_state_next = `TX_IDLE;
                    end
                end
            end
            default: w_state_next = `TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= `TX_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= C_UART_IDLE;
            r_cbsy    <= 1'b0;
            r_idle    <= 1'b1;
`ifdef EXT_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cbsy  <= (w_count_next == C_FULL_CNT);
            r_idle  <= (w_count_next == '0) && (w_state_next == `TX_IDLE);

            if (w_pop) begin
                // Load a new byte and drive the start bit on the same edge.
                r_shift   <= w_fifo_dout;
                r_baud    <= C_BAUD_RELOAD;
                r_bit_idx <= '0;
                r_txd     <= ~C_UART_IDLE;
`ifdef EXT_UART_TX_PARITY_EN
                r_parity  <= ^w_fifo_dout;
`endif
            end else begin
                case (r_state)
                    `TX_START: begin
                        if (w_bit_end) begin
                            r_baud    <= C_BAUD_RELOAD;
                            r_bit_idx <= '0;
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end else begin
                            r_baud <= r_baud - C_BAUD_W'(1);
                        end
                    end
                    `TX_DATA: begin
                        if (w_bit_end) begin
                            r_baud <= C_BAUD_RELOAD;
                            if (r_bit_idx == 3'd7) begin
`ifdef EXT_UART_TX_PARITY_EN
                                r_txd <= r_parity;
`else
                                r_txd <= C_UART_IDLE;
`endif
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                                r_txd     <= r_shift[0];
                                r_shift   <= r_shift >> 1;
                            end
                        end else begin
                            r_baud <= r_baud - C_BAUD_W'(1);
                        end
                    end
`ifdef EXT_UART_TX_PARITY_EN
                    `TX_PARITY: begin
                        if (w_bit_end) begin
                            r_baud <= C_BAUD_RELOAD;
                            r_txd  <= C_UART_IDLE;
                        end else begin
                            r_baud <= r_baud - C_BAUD_W'(1);
                        end
                    end
`endif
                    `TX_STOP: begin
                        if (w_bit_end) begin
                            // No byte waiting (a waiting byte takes the w_pop path).
                            r_baud <= '0;
                            r_txd  <= C_UART_IDLE;
                        end else begin
                            r_baud <= r_baud - C_BAUD_W'(1);
                        end
                    end
                    default: begin
                        r_baud <= '0;
                        r_txd  <= C_UART_IDLE;
                    end
                endcase
            end
        end
    end

    assign cbsy = r_cbsy;
    assign txd  = r_txd;
    assign idle = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_ext_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_uart_tx
// Description : Self-checking bench for ext_uart_tx with CLK_DIV=4 and a
//               4-entry FIFO. Frame length follows EXT_UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_uart_tx;

`ifdef EXT_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int DIV = 4;

    logic       clk;
    logic       reset;
    logic [7:0] cq;
    logic       cwre;
    logic       cbsy;
    logic       txd;
    logic       idle;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;   // hand-computed even parity of data
    } vec_t;

    vec_t vecs [6];
    vec_t burst [5];

    ext_uart_tx #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (4),
        .FIFO_AW    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cq    (cq),
        .cwre  (cwre),
        .cbsy  (cbsy),
        .txd   (txd),
        .idle  (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for a start bit, then compare every cycle of the frame
    // from cycle index 'skip' onward against the expected line pattern.
    task automatic expect_frame(input logic [7:0] d, input logic p, input int skip,
                                input int max_wait, output int waited);
        logic [FB-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef EXT_UART_TX_PARITY_EN
        f[9] = p;
`endif
        waited = 0;
        while (txd !== 1'b0 && waited < max_wait) begin
            tick;
            waited++;
        end
        for (int k = skip; k < FB * DIV; k++) begin
            check($sformatf("frame_%02h_bit%0d", d, k / DIV), {31'd0, txd}, {31'd0, f[k / DIV]});
            tick;
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        cq   = d;
        cwre = 1'b1;
        tick;
        cwre = 1'b0;
        cq   = 8'h00;
    endtask

    int w;

    initial begin
        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h80, 1'b1};
        vecs[4] = '{8'hA3, 1'b0};
        vecs[5] = '{8'h07, 1'b1};
        burst[0] = '{8'h01, 1'b1};
        burst[1] = '{8'h02, 1'b1};
        burst[2] = '{8'h03, 1'b0};
        burst[3] = '{8'h04, 1'b1};
        burst[4] = '{8'h05, 1'b0};

        // Reset and quiet line.
        reset = 1'b1;
        cq    = 8'h00;
        cwre  = 1'b0;
        repeat (3) tick;
        reset = 1'b0;
        check("reset_txd",  {31'd0, txd},  32'd1);
        check("reset_cbsy", {31'd0, cbsy}, 32'd0);
        check("reset_idle", {31'd0, idle}, 32'd1);
        for (int i = 0; i < 50; i++) begin
            tick;
            check("quiet_txd", {31'd0, txd}, 32'd1);
        end

        // Single-byte frames from the vector table.
        for (int v = 0; v < 6; v++) begin
            write_byte(vecs[v].data);
            check("single_idle_busy", {31'd0, idle}, 32'd0);
            check("single_cbsy",      {31'd0, cbsy}, 32'd0);
            expect_frame(vecs[v].data, vecs[v].par, 0, 5, w);
            check("single_latency",   w, 32'd1);
            check("single_idle_done", {31'd0, idle}, 32'd1);
            check("single_txd_done",  {31'd0, txd},  32'd1);
            repeat (2) tick;
        end

        // Five back-to-back writes fill the FIFO; a sixth while full is dropped.
        for (int i = 0; i < 5; i++) write_byte(burst[i].data);
        check("burst_cbsy_full", {31'd0, cbsy}, 32'd1);
        write_byte(8'hAA);
        check("drop_cbsy_full", {31'd0, cbsy}, 32'd1);
        // Frame 1 started on the edge after the first write: index 4 now.
        expect_frame(burst[0].data, burst[0].par, 4, 0, w);
        check("burst_cbsy_after_pop", {31'd0, cbsy}, 32'd0);
        for (int i = 1; i < 5; i++) begin
            expect_frame(burst[i].data, burst[i].par, 0, 0, w);
            check("burst_no_gap", w, 32'd0);
        end
        check("burst_idle_done", {31'd0, idle}, 32'd1);
        for (int i = 0; i < 60; i++) begin
            check("drop_no_extra_frame", {31'd0, txd}, 32'd1);
            tick;
        end

        // Reset in the middle of DATA bit 3 of 0x0F with bytes still queued.
        write_byte(8'h0F);
        write_byte(8'h11);
        write_byte(8'h22);
        repeat (16) tick;
        check("midframe_bit3", {31'd0, txd},  32'd1);
        check("midframe_idle", {31'd0, idle}, 32'd0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort_txd",  {31'd0, txd},  32'd1);
        check("abort_idle", {31'd0, idle}, 32'd1);
        check("abort_cbsy", {31'd0, cbsy}, 32'd0);
        for (int i = 0; i < 60; i++) begin
            tick;
            check("abort_no_resume", {31'd0, txd}, 32'd1);
        end

        // Still operational after the abort.
        write_byte(8'h55);
        expect_frame(8'h55, 1'b0, 0, 5, w);
        check("post_abort_latency", w, 32'd1);
        check("post_abort_idle", {31'd0, idle}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ext_uart_tx.md
Name: ext_uart_tx

Overview:
- Device-side endpoint of the CPU's EXT output channel.
- Accepts bytes presented on cq/cwre by the write-back stage and stalls it via cbsy.
- Buffers accepted bytes in a small FIFO and serialises them as 8N1 UART frames on txd.
- Sits at the top level between the CPU core and the board's serial pin.

Parameters:
- CLK_DIV, 868: clk cycles per UART bit; legal minimum 2.
- FIFO_DEPTH, 4: byte capacity of the FIFO; power of two, minimum 2.
- FIFO_AW, 2: log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cq  input  8  byte from the EXT channel.
- cwre  input  1  write strobe; byte accepted on a rising edge where cwre=1 and cbsy=0.
- cbsy  output  1  registered; 1 when the FIFO is full.
- txd  output  1  registered serial output; idle high.
- idle  output  1  registered; 1 when the FIFO is empty and the shifter is in IDLE.

Behaviour:
- Reset (synchronous, clk; applies at any time, including mid-frame):
  - txd=1, cbsy=0, idle=1.
  - FIFO count=0, pointers=0, state IDLE, baud counter=0.
  - A frame in flight is aborted; txd is high after the reset edge.
- Accept: push occurs when cwre && !cbsy. cwre while cbsy=1 is ignored and the byte is dropped (protocol violation, not flagged). cq is don't-care when cwre=0.
- FIFO:
  - count ranges 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - cbsy is registered as count_next==FIFO_DEPTH.
  - Push and pop on the same edge leave count unchanged.
  - Pop never occurs when empty; push never occurs when full.
- TX FSM, states IDLE, START, DATA, STOP (plus PARITY with the optional feature):
  - IDLE: txd=1. If count>0, pop on this edge, load the shifter, baud counter=CLK_DIV-1, go to START.
  - START: txd=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, each CLK_DIV cycles; a 3-bit index runs 0..7.
  - STOP: txd=1 for CLK_DIV cycles. On the final cycle of STOP:
    - if count>0, pop and go directly to START (no idle gap);
    - else go to IDLE.
  - The baud counter counts down; the bit ends on the cycle it reads 0, and the counter reloads to CLK_DIV-1.
- Latency: for a byte pushed on edge N into an empty, idle block, the pop happens on edge N+1 and txd=0 from edge N+1.
- Frame length: 10*CLK_DIV cycles (11*CLK_DIV with parity).
- idle is registered from (count_next==0 && state_next==IDLE).

Optional Feature:
- Macro: EXT_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - txd = XOR of the 8 data bits (even parity) for CLK_DIV cycles.
- Undefined:
  - No PARITY state; frames are 8N1.

Decomposition:
- Shared constants include:
  - TX state encodings (TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP) as `define values.
  - UART idle-level constant.
- One sub-module: ext_uart_tx_fifo.
  - Parameters FIFO_DEPTH/FIFO_AW.
  - Ports: push, din, pop, dout, count, full.
- The FSM and baud counter stay in ext_uart_tx.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4):
1. Assert reset 3 cycles, then release -> txd=1, cbsy=0, idle=1; no txd transition for 50 cycles.
2. Single write cq=0x55 at edge N -> txd=0 from edge N+1, then 1,0,1,0,1,0,1,0 (4 cycles each), then stop=1; idle=1 from edge N+41.
3. cwre held 5 consecutive edges with 0x01..0x05 -> all 5 accepted; cbsy=1 after the 5th edge; five frames emitted back-to-back with no idle gap; cbsy=0 after the pop at the end of frame 1.
4. FIFO full (cbsy=1), cwre=1 with cq=0xAA -> byte dropped; only previously accepted bytes appear on txd.
5. Reset asserted during DATA bit 3 of 0x0F -> txd=1 and idle=1 after the reset edge; remaining FIFO contents discarded; no partial frame resumes.
6. With EXT_UART_TX_PARITY_EN defined, write 0x07 -> frame start, 1,1,1,0,0,0,0,0, parity=1, stop; 44 cycles total.
